// File: rtl/eight_mux.sv
// Eight 2:1 bit selectors sharing one select, registered as a single
// atomic word with a registered valid flag.
module eight_mux (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic s,
    input  logic b4_0,
    input  logic b4_1,
    input  logic a3_0,
    input  logic a3_1,
    input  logic b3_0,
    input  logic b3_1,
    input  logic a2_0,
    input  logic a2_1,
    input  logic b2_0,
    input  logic b2_1,
    input  logic a1_0,
    input  logic a1_1,
    input  logic b1_0,
    input  logic b1_1,
    input  logic a0_0,
    input  logic a0_1,
    output logic b4,
    output logic a3,
    output logic b3,
    output logic a2,
    output logic b2,
    output logic a1,
    output logic b1,
    output logic a0,
    output logic out_valid
);

    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] data_d;
    logic [7:0] data_q;
    logic       valid_d;
    logic       valid_q;

    // Word order: b4 (msb) down to a0 (lsb)
    assign in0 = {b4_0, a3_0, b3_0, a2_0, b2_0, a1_0, b1_0, a0_0};
    assign in1 = {b4_1, a3_1, b3_1, a2_1, b2_1, a1_1, b1_1, a0_1};

    always_comb begin
        data_d  = data_q;
        valid_d = in_valid;
        if (in_valid) begin
            data_d = s ? in1 : in0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign {b4, a3, b3, a2, b2, a1, b1, a0} = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_eight_mux.sv
// Randomized self-checking bench for eight_mux against a word-level
// reference model.
module tb_eight_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       s;
    logic [7:0] x;
    logic [7:0] y;
    logic       b4, a3, b3, a2, b2, a1, b1, a0, out_valid;
    logic [7:0] obs;
    logic [7:0] m_data;
    logic       m_valid;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    eight_mux dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s),
        .b4_0(x[7]), .b4_1(y[7]),
        .a3_0(x[6]), .a3_1(y[6]),
        .b3_0(x[5]), .b3_1(y[5]),
        .a2_0(x[4]), .a2_1(y[4]),
        .b2_0(x[3]), .b2_1(y[3]),
        .a1_0(x[2]), .a1_1(y[2]),
        .b1_0(x[1]), .b1_1(y[1]),
        .a0_0(x[0]), .a0_1(y[0]),
        .b4(b4), .a3(a3), .b3(b3), .a2(a2),
        .b2(b2), .a1(a1), .b1(b1), .a0(a0),
        .out_valid(out_valid)
    );

    assign obs = {b4, a3, b3, a2, b2, a1, b1, a0};

    task automatic chk(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model, compare just after the edge
    task automatic cyc(input string tag, input logic v, input logic sel,
                       input logic [7:0] xx, input logic [7:0] yy);
        in_valid = v;
        s        = sel;
        x        = xx;
        y        = yy;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_data  = 8'h00;
            m_valid = 1'b0;
        end else begin
            if (v) m_data = sel ? yy : xx;
            m_valid = v;
        end
        chk(tag, {out_valid, obs}, {m_valid, m_data});
    endtask

    initial begin
        m_data   = 8'h00;
        m_valid  = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        s        = 1'b0;
        x        = 8'hA5;
        y        = 8'h3C;
        #3;
        chk("reset_async", {out_valid, obs}, 9'h000);
        cyc("reset_hold", 1'b1, 1'b1, 8'hFF, 8'hFF);
        cyc("reset_hold", 1'b1, 1'b0, 8'hFF, 8'hFF);
        rst_n = 1'b1;

        cyc("sel0_ones", 1'b1, 1'b0, 8'hFF, 8'h00);
        chk("sel0_exact", {out_valid, obs}, 9'h1FF);
        cyc("sel1_zeros", 1'b1, 1'b1, 8'hFF, 8'h00);
        chk("sel1_exact", {out_valid, obs}, 9'h100);
        cyc("sel1_inv", 1'b1, 1'b1, 8'h00, 8'hFF);
        chk("sel1_inv_exact", {out_valid, obs}, 9'h1FF);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) begin
                cyc("sweep_x", 1'b1, k[0], 8'(i), 8'($urandom));
                cyc("sweep_y", 1'b1, k[0], 8'($urandom), 8'(i));
            end
        end

        cyc("hold_cap", 1'b1, 1'b0, 8'h5A, 8'hC3);
        for (int i = 0; i < 3; i++) begin
            cyc("hold", 1'b0, i[0], ~x, ~y);
            chk("hold_exact", {out_valid, obs}, 9'h05A);
        end

        cyc("mid_pre", 1'b1, 1'b1, 8'h00, 8'hE7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async", {out_valid, obs}, 9'h000);
        cyc("mid_low", 1'b1, 1'b1, 8'hFF, 8'hFF);
        rst_n = 1'b1;
        cyc("mid_post", 1'b1, 1'b0, 8'h81, 8'h7E);
        chk("mid_post_exact", {out_valid, obs}, 9'h181);

        for (int i = 0; i < 600; i++) begin
            cyc("random", 1'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eight_mux.md
EIGHT_MUX -- requirements
Module: eight_mux

Interface
REQ-001 Parameters: none; all data signals are 1 bit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  input sample qualifier; capture only when high.
REQ-005 s  input  1  select: 0 picks the *_0 inputs, 1 picks the *_1 inputs.
REQ-006 b4_0, b4_1  input  1 each  candidates for b4.
REQ-007 a3_0, a3_1, b3_0, b3_1  input  1 each  candidates for a3, b3.
REQ-008 a2_0, a2_1, b2_0, b2_1  input  1 each  candidates for a2, b2.
REQ-009 a1_0, a1_1, b1_0, b1_1  input  1 each  candidates for a1, b1.
REQ-010 a0_0, a0_1  input  1 each  candidates for a0.
REQ-011 b4, a3, b3, a2, b2, a1, b1, a0  output  1 each  registered selected bits.
REQ-012 out_valid  output  1  high for the cycle after a captured sample.

Function
REQ-013 Eight independent 2:1 selections share the single select s.
- For each output X in {b4,a3,b3,a2,b2,a1,b1,a0}: X_next = s ? X_1 : X_0.
REQ-014 On a rising clk edge with in_valid=1, all eight outputs load X_next together.
- Loading is atomic: no mixing of old and new bits.
REQ-015 Latency is exactly 1 cycle from the in_valid=1 edge to the updated outputs.
REQ-016 With in_valid=0, the outputs hold their previous values.
- Changes on s or the data inputs have no effect while in_valid=0.
REQ-017 out_valid is a registered copy of in_valid.
- out_valid is 1 in the cycle following each capture edge and 0 otherwise.
REQ-018 No combinational path runs from any input to any output.
REQ-019 Back-to-back in_valid=1 cycles produce a new result every cycle, with no bubbles.
REQ-020 Selection is bitwise only: no arithmetic and no inversion.
- Each output equals exactly one input bit.

Reset
REQ-021 rst_n=0 immediately forces all eight data outputs and out_valid to 0, independent of clk.
REQ-022 While rst_n=0, in_valid and data inputs are ignored; outputs stay 0.
REQ-023 Reset asserted mid-stream discards any pending capture.
- The first capture after reset occurs on the first rising edge with rst_n=1 and in_valid=1.
REQ-024 Reset deassertion requires no release delay beyond one edge.
- The first edge with rst_n=1 may capture.

Verification
REQ-025 Reset check: assert rst_n=0 with arbitrary inputs.
- Required response: all outputs=0 and out_valid=0 at once, before any clk edge.
REQ-026 Select-0 check: s=0, all *_0=1, all *_1=0, in_valid=1, one edge.
- Required response: all eight outputs=1 and out_valid=1.
REQ-027 Select-1 check: s=1 with the same data values as REQ-026.
- Required response: all eight outputs=0.
- Then invert the data (all *_0=0, all *_1=1): all eight outputs=1 after one edge.
REQ-028 Exhaustive check: for s in {0,1}, sweep x over 0..255 on the eight *_0 inputs and y over 0..255 on the eight *_1 inputs.
- Bit order for both: b4,a3,b3,a2,b2,a1,b1,a0.
- Required response: outputs {b4..a0} equal x when s=0 and y when s=1, one cycle after each capture.
- A mismatch counter must end at 0.
REQ-029 Hold check: capture a pattern, drop in_valid, then toggle s and all inputs for 3 cycles.
- Required response: outputs stay unchanged and out_valid=0.
REQ-030 Mid-stream reset check: pulse rst_n low between two in_valid=1 cycles.
- Required response: outputs=0 during reset.
- The next capture after release reflects only post-reset inputs.
